// File: rtl/control_sequencer_pkg.sv
// Shared definitions for control_sequencer: opcodes, FSM state encodings and the datapath strobe bundle.
package control_sequencer_pkg;

    localparam int unsigned OPC_NOP  = 0;
    localparam int unsigned OPC_ADD  = 3;
    localparam int unsigned OPC_SUB  = 4;
    localparam int unsigned OPC_AND  = 5;
    localparam int unsigned OPC_OR   = 6;
    localparam int unsigned OPC_SHR  = 7;
    localparam int unsigned OPC_SHL  = 8;
    localparam int unsigned OPC_HALT = 31;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_HALT = 4'd7,
        ST_ERR  = 4'd8
    } state_t;

    // One bit per datapath control strobe, in datapath port order.
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic zlow_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic r_in;
        logic r_out;
    } strobes_t;

    // ALU opcodes form one contiguous range ADD..SHL.
    function automatic logic is_alu_opc(input int unsigned opc);
        return (opc >= OPC_ADD) && (opc <= OPC_SHL);
    endfunction

endpackage

// File: rtl/control_sequencer_ir_decoder.sv
// Combinational IR field splitter: opcode, Ra, Rb, Rc (MSB first) and opcode class flags.
module control_sequencer_ir_decoder
    import control_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OPC_W  = 5,
    parameter int unsigned RSEL_W = 4
) (
    input  logic [DATA_W-1:0] ir,
    output logic [OPC_W-1:0]  opcode_c,
    output logic [RSEL_W-1:0] ra_c,
    output logic [RSEL_W-1:0] rb_c,
    output logic [RSEL_W-1:0] rc_c,
    output logic              legal_alu_c,
    output logic              is_nop_c,
    output logic              is_halt_c
);

    localparam int unsigned OPC_LSB = DATA_W - OPC_W;
    localparam int unsigned RA_LSB  = OPC_LSB - RSEL_W;
    localparam int unsigned RB_LSB  = RA_LSB - RSEL_W;
    localparam int unsigned RC_LSB  = RB_LSB - RSEL_W;

    assign opcode_c = ir[DATA_W-1 -: OPC_W];
    assign ra_c     = ir[RA_LSB +: RSEL_W];
    assign rb_c     = ir[RB_LSB +: RSEL_W];
    assign rc_c     = ir[RC_LSB +: RSEL_W];

    assign legal_alu_c = is_alu_opc(32'(opcode_c));
    assign is_nop_c    = (opcode_c == OPC_W'(OPC_NOP));
    assign is_halt_c   = (opcode_c == OPC_W'(OPC_HALT));

    // Immediate/low IR bits carry no control information.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the two-register ALU datapath.
// Optional SINGLE_STEP_EN adds a step input that gates every state advance.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OPC_W  = 5,
    parameter int unsigned RSEL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] ir,
    input  logic              mem_rdy,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              pc_out,
    output logic              mar_in,
    output logic              inc_pc,
    output logic              z_in,
    output logic              zlow_out,
    output logic              pc_in,
    output logic              read,
    output logic              mdr_in,
    output logic              mdr_out,
    output logic              ir_in,
    output logic              y_in,
    output logic              r_in,
    output logic              r_out,
    output logic [RSEL_W-1:0] reg_sel,
    output logic [OPC_W-1:0]  alu_op,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_cnt
);

    state_t            state_q;
    state_t            state_d;
    strobes_t          str_c;
    logic              advance_c;
    logic              retire_c;

    logic [OPC_W-1:0]  opcode_c;
    logic [RSEL_W-1:0] ra_c;
    logic [RSEL_W-1:0] rb_c;
    logic [RSEL_W-1:0] rc_c;
    logic              legal_alu_c;
    logic              is_nop_c;
    logic              is_halt_c;

    control_sequencer_ir_decoder #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W),
        .RSEL_W (RSEL_W)
    ) u_ir_decoder (
        .ir          (ir),
        .opcode_c    (opcode_c),
        .ra_c        (ra_c),
        .rb_c        (rb_c),
        .rc_c        (rc_c),
        .legal_alu_c (legal_alu_c),
        .is_nop_c    (is_nop_c),
        .is_halt_c   (is_halt_c)
    );

`ifdef SINGLE_STEP_EN
    assign advance_c = step;
`else
    assign advance_c = 1'b1;
`endif

    // State register; reset wins over a held (non-stepping) cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (advance_c) begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt <= '0;
        end else if (advance_c && retire_c && (instr_cnt != {CNT_W{1'b1}})) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        str_c    = '0;
        reg_sel  = '0;
        alu_op   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_T0;
            end
            ST_T0: begin
                str_c.pc_out = 1'b1;
                str_c.mar_in = 1'b1;
                str_c.inc_pc = 1'b1;
                str_c.z_in   = 1'b1;
                state_d      = ST_T1;
            end
            ST_T1: begin
                str_c.zlow_out = 1'b1;
                str_c.pc_in    = 1'b1;
                str_c.read     = 1'b1;
                str_c.mdr_in   = 1'b1;
                if (mem_rdy) state_d = ST_T2;
            end
            ST_T2: begin
                str_c.mdr_out = 1'b1;
                str_c.ir_in   = 1'b1;
                state_d       = ST_T3;
            end
            ST_T3: begin
                if (legal_alu_c) begin
                    str_c.r_out = 1'b1;
                    str_c.y_in  = 1'b1;
                    reg_sel     = rb_c;
                    state_d     = ST_T4;
                end else if (is_nop_c) begin
                    retire_c = 1'b1;
                    state_d  = run ? ST_T0 : ST_IDLE;
                end else if (is_halt_c) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_T4: begin
                str_c.r_out = 1'b1;
                str_c.z_in  = 1'b1;
                reg_sel     = rc_c;
                alu_op      = opcode_c;
                state_d     = ST_T5;
            end
            ST_T5: begin
                str_c.zlow_out = 1'b1;
                str_c.r_in     = 1'b1;
                reg_sel        = ra_c;
                retire_c       = 1'b1;
                state_d        = run ? ST_T0 : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERR);
    assign halted  = (state_q == ST_HALT);
    assign illegal = (state_q == ST_ERR);

    assign pc_out   = str_c.pc_out;
    assign mar_in   = str_c.mar_in;
    assign inc_pc   = str_c.inc_pc;
    assign z_in     = str_c.z_in;
    assign zlow_out = str_c.zlow_out;
    assign pc_in    = str_c.pc_in;
    assign read     = str_c.read;
    assign mdr_in   = str_c.mdr_in;
    assign mdr_out  = str_c.mdr_out;
    assign ir_in    = str_c.ir_in;
    assign y_in     = str_c.y_in;
    assign r_in     = str_c.r_in;
    assign r_out    = str_c.r_out;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: instructions are expanded into per-cycle expected outputs.
module tb_control_sequencer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned RSEL_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PAD_W  = DATA_W - OPC_W - 3 * RSEL_W;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`ifdef SINGLE_STEP_EN
    localparam int unsigned SP = 4;
`else
    localparam int unsigned SP = 1;
`endif

    // Strobe order: pc_out mar_in inc_pc z_in zlow_out pc_in read mdr_in mdr_out ir_in y_in r_in r_out
    localparam logic [12:0] F_NONE = 13'b0000_0000_000_00;
    localparam logic [12:0] F_T0   = 13'b1111_0000_000_00;
    localparam logic [12:0] F_T1   = 13'b0000_1111_000_00;
    localparam logic [12:0] F_T2   = 13'b0000_0000_110_00;
    localparam logic [12:0] F_T3   = 13'b0000_0000_001_01;
    localparam logic [12:0] F_T4   = 13'b0001_0000_000_01;
    localparam logic [12:0] F_T5   = 13'b0000_1000_000_10;

    localparam int unsigned END_RUN   = 0;
    localparam int unsigned END_IDLE  = 1;
    localparam int unsigned END_STUCK = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              mem_rdy;
    logic [DATA_W-1:0] ir;
`ifdef SINGLE_STEP_EN
    logic              step;
`endif
    logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in;
    logic mdr_out, ir_in, y_in, r_in, r_out, busy, halted, illegal;
    logic [RSEL_W-1:0] reg_sel;
    logic [OPC_W-1:0]  alu_op;
    logic [CNT_W-1:0]  instr_cnt;

    control_sequencer #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W),
        .RSEL_W (RSEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .ir        (ir),
        .mem_rdy   (mem_rdy),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .pc_out    (pc_out),
        .mar_in    (mar_in),
        .inc_pc    (inc_pc),
        .z_in      (z_in),
        .zlow_out  (zlow_out),
        .pc_in     (pc_in),
        .read      (read),
        .mdr_in    (mdr_in),
        .mdr_out   (mdr_out),
        .ir_in     (ir_in),
        .y_in      (y_in),
        .r_in      (r_in),
        .r_out     (r_out),
        .reg_sel   (reg_sel),
        .alu_op    (alu_op),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0]       strb;
        logic [RSEL_W-1:0] sel;
        logic [OPC_W-1:0]  op;
        logic              busy;
        logic              halted;
        logic              illegal;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Architectural model state.
    int   model_cnt  = 0;
    logic model_halt = 1'b0;
    logic model_ill  = 1'b0;

    function automatic logic rb1();
        return 1'($urandom);
    endfunction

    function automatic exp_t mk(input logic [12:0] s, input logic [RSEL_W-1:0] sel,
                                input logic [OPC_W-1:0] op, input logic b);
        exp_t e;
        e.strb    = s;
        e.sel     = sel;
        e.op      = op;
        e.busy    = b;
        e.halted  = model_halt;
        e.illegal = model_ill;
        e.cnt     = CNT_W'(model_cnt);
        return e;
    endfunction

    function automatic void retire();
        if (model_cnt < int'(CNT_MAX)) model_cnt++;
    endfunction

    // One architectural cycle, stretched to SP clocks (step on the last) when single-stepping.
    task automatic tick(input logic r_run, input logic r_rdy, input logic r_reset,
                        input exp_t e, input int unsigned period);
        for (int unsigned i = 0; i < period; i++) begin
            run     = r_run;
            mem_rdy = r_rdy;
            reset   = r_reset;
`ifdef SINGLE_STEP_EN
            step    = (i == period - 1);
`endif
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input int unsigned opc_i, input int unsigned waits,
                             input logic run_next, input logic abort_t4,
                             output int unsigned ending);
        logic [OPC_W-1:0]  opc;
        logic [RSEL_W-1:0] ra, rb, rc;
        logic [PAD_W-1:0]  pad;
        opc = OPC_W'(opc_i);
        ra  = RSEL_W'($urandom);
        rb  = RSEL_W'($urandom);
        rc  = RSEL_W'($urandom);
        pad = PAD_W'($urandom);
        ir  = {opc, ra, rb, rc, pad};
        ending = END_RUN;
        tick(rb1(), rb1(), 1'b0, mk(F_T0, '0, '0, 1'b1), SP);
        for (int unsigned w = 0; w < waits; w++)
            tick(rb1(), 1'b0, 1'b0, mk(F_T1, '0, '0, 1'b1), SP);
        tick(rb1(), 1'b1, 1'b0, mk(F_T1, '0, '0, 1'b1), SP);
        tick(rb1(), rb1(), 1'b0, mk(F_T2, '0, '0, 1'b1), SP);
        if (opc_i >= 3 && opc_i <= 8) begin
            tick(rb1(), rb1(), 1'b0, mk(F_T3, rb, '0, 1'b1), SP);
            if (abort_t4) begin
                tick(rb1(), rb1(), 1'b1, mk(F_T4, rc, opc, 1'b1), 1);
                model_cnt = 0;
                ending = END_IDLE;
            end else begin
                tick(rb1(), rb1(), 1'b0, mk(F_T4, rc, opc, 1'b1), SP);
                tick(run_next, rb1(), 1'b0, mk(F_T5, ra, '0, 1'b1), SP);
                retire();
                ending = run_next ? END_RUN : END_IDLE;
            end
        end else if (opc_i == 0) begin
            tick(run_next, rb1(), 1'b0, mk(F_NONE, '0, '0, 1'b1), SP);
            retire();
            ending = run_next ? END_RUN : END_IDLE;
        end else begin
            tick(rb1(), rb1(), 1'b0, mk(F_NONE, '0, '0, 1'b1), SP);
            if (opc_i == 31) model_halt = 1'b1;
            else             model_ill  = 1'b1;
            ending = END_STUCK;
        end
    endtask

    task automatic idle_then_start();
        int n;
        n = int'($urandom_range(0, 3));
        for (int i = 0; i < n; i++)
            tick(1'b0, rb1(), 1'b0, mk(F_NONE, '0, '0, 1'b0), SP);
        tick(1'b1, rb1(), 1'b0, mk(F_NONE, '0, '0, 1'b0), SP);
    endtask

    task automatic sticky_then_reset();
        int n;
        n = int'($urandom_range(2, 5));
        for (int i = 0; i < n; i++)
            tick(rb1(), rb1(), 1'b0, mk(F_NONE, '0, '0, 1'b0), SP);
        tick(rb1(), rb1(), 1'b1, mk(F_NONE, '0, '0, 1'b0), 1);
        model_cnt  = 0;
        model_halt = 1'b0;
        model_ill  = 1'b0;
    endtask

    task automatic do_instr(input int unsigned opc_i, input int unsigned waits,
                            input logic run_next, input logic abort_t4);
        int unsigned ending;
        run_instr(opc_i, waits, run_next, abort_t4, ending);
        if (ending == END_STUCK) begin
            sticky_then_reset();
            idle_then_start();
        end else if (ending == END_IDLE) begin
            idle_then_start();
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest expected entry every cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb_q.pop_front();
            a.strb    = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
                         mdr_out, ir_in, y_in, r_in, r_out};
            a.sel     = reg_sel;
            a.op      = alu_op;
            a.busy    = busy;
            a.halted  = halted;
            a.illegal = illegal;
            a.cnt     = instr_cnt;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle_check t=%0t got strb=%h sel=%h op=%h busy=%b halt=%b ill=%b cnt=%h want strb=%h sel=%h op=%h busy=%b halt=%b ill=%b cnt=%h",
                         $time, a.strb, a.sel, a.op, a.busy, a.halted, a.illegal, a.cnt,
                         e.strb, e.sel, e.op, e.busy, e.halted, e.illegal, e.cnt);
            end
        end
    end

    initial begin
        int unsigned kind;
        int unsigned opc;
        reset   = 1'b1;
        run     = 1'b0;
        mem_rdy = 1'b0;
        ir      = '0;
`ifdef SINGLE_STEP_EN
        step    = 1'b0;
`endif
        @(posedge clk);
        #1;
        tick(1'b0, 1'b0, 1'b1, mk(F_NONE, '0, '0, 1'b0), 1);
        idle_then_start();

        // Directed: AND R1,R2,R3 from the datapath bench, then a memory-wait fetch.
        begin
            int unsigned ending;
            ir = 32'h2891_8000;
            tick(1'b1, 1'b1, 1'b0, mk(F_T0, '0, '0, 1'b1), SP);
            tick(1'b1, 1'b1, 1'b0, mk(F_T1, '0, '0, 1'b1), SP);
            tick(1'b1, 1'b1, 1'b0, mk(F_T2, '0, '0, 1'b1), SP);
            tick(1'b1, 1'b1, 1'b0, mk(F_T3, 4'd2, '0, 1'b1), SP);
            tick(1'b1, 1'b1, 1'b0, mk(F_T4, 4'd3, 5'd5, 1'b1), SP);
            tick(1'b1, 1'b1, 1'b0, mk(F_T5, 4'd1, '0, 1'b1), SP);
            retire();
            run_instr(3, 3, 1'b1, 1'b0, ending);
        end
        // Directed: HALT, illegal 0x0A, abort in T4, run dropped at end.
        do_instr(31, 0, 1'b1, 1'b0);
        do_instr(10, 1, 1'b1, 1'b0);
        do_instr(4, 0, 1'b1, 1'b1);
        do_instr(6, 0, 1'b0, 1'b0);
        do_instr(0, 0, 1'b0, 1'b0);
        // Directed: run counter into saturation.
        for (int i = 0; i < 18; i++) do_instr((i % 2 == 0) ? 0 : 7, 0, 1'b1, 1'b0);

        // Randomized instruction mix.
        for (int i = 0; i < 70; i++) begin
            kind = $urandom_range(0, 99);
            if (kind < 65)      opc = 3 + $urandom_range(0, 5);
            else if (kind < 78) opc = 0;
            else if (kind < 83) opc = 31;
            else if (kind < 90) begin
                opc = $urandom_range(1, 24);
                if (opc >= 3) opc = opc + 6;
            end else            opc = 3 + $urandom_range(0, 5);
            do_instr(opc, $urandom_range(0, 3), ($urandom_range(0, 3) != 0), (kind >= 94));
        end

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
